// File: rtl/lbist_pkg.sv
// Shared encodings for the LBIST pattern counter: end-of-count modes,
// controller states and the datapath operation select.
package lbist_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_SET  = 2'b10,
    OP_STEP = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/lbist_pattern_counter_if.sv
// Control/status bundle between the BIST controller (master) and the
// pattern counter (slave).
interface lbist_pattern_counter_if #(
  parameter int BITS = 8
) ();

  logic            start;
  logic            stop;
  logic            inc;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] term;
  logic [1:0]      mode;
  logic            dir;
  logic [BITS-1:0] counter;
  logic            busy;
  logic            done;
  logic            at_end;
  logic            ovf;

  modport master (
    output start, stop, inc, load, load_val, term, mode, dir,
    input  counter, busy, done, at_end, ovf
  );

  modport slave (
    input  start, stop, inc, load, load_val, term, mode, dir,
    output counter, busy, done, at_end, ovf
  );

endinterface

// File: rtl/lbist_count_core.sv
// Up/down count register with clamped load, plus the end-value compare
// (live for the FSM, registered for the at_end flag).
module lbist_count_core
  import lbist_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  cnt_op_e         i_op,
  input  logic            i_down,
  input  logic [BITS-1:0] i_load_val,
  input  logic [BITS-1:0] i_clamp,
  input  logic [BITS-1:0] i_set_val,
  input  logic [BITS-1:0] i_end_cur,
  input  logic [BITS-1:0] i_end_next,
  output logic [BITS-1:0] o_count,
  output logic            o_at_end,
  output logic            o_at_end_now
);

  logic [BITS-1:0] r_count;
  logic            r_at_end;
  logic [BITS-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    case (i_op)
      OP_LOAD: w_count_next = (i_load_val > i_clamp) ? i_clamp : i_load_val;
      OP_SET:  w_count_next = i_set_val;
      OP_STEP: w_count_next = i_down ? (r_count - BITS'(1)) : (r_count + BITS'(1));
      default: w_count_next = r_count;
    endcase
  end

  // at_end only refreshes on a counter write, so it stays low out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_at_end <= 1'b0;
    end else if (i_op != OP_HOLD) begin
      r_count  <= w_count_next;
      r_at_end <= (w_count_next == i_end_next);
    end
  end

  assign o_count      = r_count;
  assign o_at_end     = r_at_end;
  assign o_at_end_now = (r_count == i_end_cur);

endmodule

// File: rtl/lbist_pattern_counter.sv
// LBIST pattern/session counter: IDLE/RUN control, sampled session config
// and the done/ovf flags around the lbist_count_core datapath.
module lbist_pattern_counter
  import lbist_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  lbist_pattern_counter_if.slave  bus
);

  logic [0:0]      r_state;
  logic [1:0]      r_mode;
  logic            r_dir;
  logic [BITS-1:0] r_term;
  logic            r_done;
  logic            r_ovf;

  logic [0:0]      w_state_next;
  logic [1:0]      w_mode_next;
  logic            w_dir_next;
  logic [BITS-1:0] w_term_next;
  logic            w_done_next;
  logic            w_ovf_next;
  cnt_op_e         w_op;
  logic [BITS-1:0] w_set_val;
  logic [BITS-1:0] w_clamp;
  logic [BITS-1:0] w_end_cur;
  logic [BITS-1:0] w_end_next;
  logic [BITS-1:0] w_count;
  logic            w_at_end;
  logic            w_at_end_now;
  logic            w_near_end;

  assign w_end_cur  = r_dir ? '0 : r_term;
  assign w_end_next = w_dir_next ? '0 : w_term_next;
  assign w_clamp    = (r_state == ST_IDLE) ? bus.term : r_term;
  assign w_near_end = r_dir ? (w_count == BITS'(1)) : (w_count == r_term - BITS'(1));

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_dir_next   = r_dir;
    w_term_next  = r_term;
    w_done_next  = 1'b0;
    w_ovf_next   = r_ovf;
    w_op         = OP_HOLD;
    w_set_val    = r_dir ? r_term : '0;

    if (bus.stop) begin
      w_state_next = ST_IDLE;
    end else if (bus.load) begin
      w_op = OP_LOAD;
    end else if (bus.start) begin
      w_mode_next  = bus.mode;
      w_dir_next   = bus.dir;
      w_term_next  = bus.term;
      w_ovf_next   = 1'b0;
      w_state_next = ST_RUN;
      w_op         = OP_SET;
      w_set_val    = bus.dir ? bus.term : '0;
    end else if (bus.inc && (r_state == ST_RUN)) begin
      if (!w_at_end_now) begin
        w_op = OP_STEP;
        // saturate reports completion on the step that lands on end
        w_done_next = (r_mode == MODE_SAT) && w_near_end;
      end else if (r_mode == MODE_WRAP) begin
        w_op        = OP_SET;
        w_done_next = 1'b1;
      end else if (r_mode == MODE_SAT) begin
        w_ovf_next = 1'b1;
      end else begin
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_WRAP;
      r_dir   <= 1'b0;
      r_term  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_dir   <= w_dir_next;
      r_term  <= w_term_next;
      r_done  <= w_done_next;
      r_ovf   <= w_ovf_next;
    end
  end

  lbist_count_core #(
    .BITS(BITS)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_op         (w_op),
    .i_down       (r_dir),
    .i_load_val   (bus.load_val),
    .i_clamp      (w_clamp),
    .i_set_val    (w_set_val),
    .i_end_cur    (w_end_cur),
    .i_end_next   (w_end_next),
    .o_count      (w_count),
    .o_at_end     (w_at_end),
    .o_at_end_now (w_at_end_now)
  );

  assign bus.counter = w_count;
  assign bus.at_end  = w_at_end;
  assign bus.busy    = (r_state == ST_RUN);
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_lbist_pattern_counter.sv
// Directed bench for lbist_pattern_counter (BITS=8) with hand-computed
// expected values; outputs are sampled 1 time unit after each rising edge.
module tb_lbist_pattern_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_done;

  int wrap_cnt  [7] = '{1, 0, 2, 1, 0, 2, 1};
  int wrap_done [7] = '{0, 0, 1, 0, 0, 1, 0};

  lbist_pattern_counter_if #(.BITS(8)) bus ();

  lbist_pattern_counter #(
    .BITS(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.inc      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
  endtask

  task automatic do_start(input logic [7:0] t, input logic [1:0] m, input logic d);
    bus.term  = t;
    bus.mode  = m;
    bus.dir   = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_done   = 0;
    rst      = 1'b0;
    idle_inputs();
    bus.term = 8'd0;
    bus.mode = 2'b00;
    bus.dir  = 1'b0;

    // reset values
    repeat (3) tick();
    rst = 1'b1;
    check_eq("rst_counter", bus.counter, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_at_end", bus.at_end, 0);
    check_eq("rst_ovf", bus.ovf, 0);

    bus.inc = 1'b1;
    repeat (3) tick();
    check_eq("idle_inc_counter", bus.counter, 0);
    check_eq("idle_inc_busy", bus.busy, 0);

    // asynchronous reset in the middle of a session
    bus.inc = 1'b0;
    do_start(8'd10, 2'b00, 1'b0);
    bus.inc = 1'b1;
    repeat (5) tick();
    check_eq("pre_rst_counter", bus.counter, 5);
    rst = 1'b0;
    #1;
    check_eq("async_rst_counter", bus.counter, 0);
    check_eq("async_rst_busy", bus.busy, 0);
    check_eq("async_rst_ovf", bus.ovf, 0);
    #1;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_counter", bus.counter, 0);
    check_eq("post_rst_busy", bus.busy, 0);

    // up, one-shot, term=3
    bus.inc = 1'b0;
    do_start(8'd3, 2'b10, 1'b0);
    check_eq("os_start_counter", bus.counter, 0);
    check_eq("os_start_busy", bus.busy, 1);
    bus.inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("os_step%0d_counter", i), bus.counter, i);
      check_eq($sformatf("os_step%0d_done", i), bus.done, 0);
    end
    check_eq("os_at_end", bus.at_end, 1);
    tick();
    check_eq("os_done", bus.done, 1);
    check_eq("os_busy_fall", bus.busy, 0);
    check_eq("os_hold", bus.counter, 3);
    tick();
    check_eq("os_done_one_cycle", bus.done, 0);
    check_eq("os_idle_counter", bus.counter, 3);

    // down, wrap, term=2
    bus.inc = 1'b0;
    do_start(8'd2, 2'b00, 1'b1);
    check_eq("wrap_start_counter", bus.counter, 2);
    check_eq("wrap_start_at_end", bus.at_end, 0);
    bus.inc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("wrap_step%0d_counter", i + 1), bus.counter, wrap_cnt[i]);
      check_eq($sformatf("wrap_step%0d_done", i + 1), bus.done, wrap_done[i]);
    end

    // up, saturate, term=255; start and inc asserted together on cycle 1
    bus.term  = 8'd255;
    bus.mode  = 2'b01;
    bus.dir   = 1'b0;
    bus.start = 1'b1;
    bus.inc   = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("sat_start_counter", bus.counter, 0);
    n_done = 0;
    for (int i = 2; i <= 258; i++) begin
      tick();
      if (bus.done) n_done++;
      if (i == 255) begin
        check_eq("sat_c255_counter", bus.counter, 254);
        check_eq("sat_c255_ovf", bus.ovf, 0);
      end
      if (i == 256) begin
        check_eq("sat_c256_counter", bus.counter, 255);
        check_eq("sat_c256_done", bus.done, 1);
        check_eq("sat_c256_ovf", bus.ovf, 0);
      end
      if (i == 257) begin
        check_eq("sat_c257_counter", bus.counter, 255);
        check_eq("sat_c257_ovf", bus.ovf, 1);
      end
    end
    check_eq("sat_done_count", n_done, 1);
    check_eq("sat_final_counter", bus.counter, 255);
    check_eq("sat_final_ovf", bus.ovf, 1);
    bus.inc = 1'b0;
    do_start(8'd255, 2'b01, 1'b0);
    check_eq("sat_restart_ovf", bus.ovf, 0);
    check_eq("sat_restart_counter", bus.counter, 0);
    check_eq("sat_restart_busy", bus.busy, 1);

    // priority and clamp, term=10, wrap
    do_start(8'd10, 2'b00, 1'b0);
    bus.load     = 1'b1;
    bus.load_val = 8'd20;
    tick();
    check_eq("clamp_counter", bus.counter, 10);
    check_eq("clamp_at_end", bus.at_end, 1);
    check_eq("clamp_busy", bus.busy, 1);
    bus.load_val = 8'd5;
    tick();
    bus.load = 1'b0;
    check_eq("load5_counter", bus.counter, 5);
    bus.term = 8'd4;
    bus.inc  = 1'b1;
    repeat (5) tick();
    check_eq("midrun_term_counter", bus.counter, 10);
    check_eq("midrun_term_at_end", bus.at_end, 1);
    tick();
    check_eq("midrun_wrap_counter", bus.counter, 0);
    check_eq("midrun_wrap_done", bus.done, 1);
    tick();
    check_eq("pre_stop_counter", bus.counter, 1);
    bus.stop     = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'd7;
    tick();
    check_eq("stop_prio_busy", bus.busy, 0);
    check_eq("stop_prio_counter", bus.counter, 1);
    check_eq("stop_prio_done", bus.done, 0);
    bus.stop     = 1'b0;
    bus.inc      = 1'b0;
    bus.load_val = 8'd9;
    tick();
    bus.load = 1'b0;
    check_eq("idle_live_clamp", bus.counter, 4);
    check_eq("idle_load_busy", bus.busy, 0);

    // term=0, one-shot and reserved mode
    do_start(8'd0, 2'b10, 1'b0);
    check_eq("t0_start_at_end", bus.at_end, 1);
    bus.inc = 1'b1;
    tick();
    check_eq("t0_done", bus.done, 1);
    check_eq("t0_busy", bus.busy, 0);
    check_eq("t0_counter", bus.counter, 0);
    bus.inc = 1'b0;
    do_start(8'd0, 2'b11, 1'b0);
    bus.inc = 1'b1;
    tick();
    check_eq("rsvd_done", bus.done, 1);
    check_eq("rsvd_busy", bus.busy, 0);

    // no inc for 20 cycles in RUN
    bus.inc = 1'b0;
    do_start(8'd10, 2'b00, 1'b0);
    bus.load     = 1'b1;
    bus.load_val = 8'd6;
    tick();
    bus.load = 1'b0;
    repeat (20) tick();
    check_eq("stable_counter", bus.counter, 6);
    check_eq("stable_busy", bus.busy, 1);
    check_eq("stable_done", bus.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
